// File: rtl/fsrc_seq_pkg.sv
// rtl/fsrc_seq_pkg.sv - shared state type and default widths for the FSRC sequencer
package fsrc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } fsrc_seq_state_t;

  localparam int DEF_NUM_TRIG      = 4;
  localparam int DEF_COUNTER_WIDTH = 8;
  localparam int DEF_PW_WIDTH      = 4;
  localparam int DEF_REPEAT_WIDTH  = 8;
  localparam int SEQ_CNT_WIDTH     = 16;

endpackage

// File: rtl/fsrc_trig_stretch.sv
// rtl/fsrc_trig_stretch.sv - reload-on-fire pulse stretcher for one trigger channel
module fsrc_trig_stretch
  import fsrc_seq_pkg::*;
#(
  parameter int PW_WIDTH = DEF_PW_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                fire,
  input  logic [PW_WIDTH-1:0] width,
  output logic                pulse
);

  logic [PW_WIDTH-1:0] cnt;

  // Load the width on fire, then count down; pulse is high while cycles remain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (clear) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (fire) begin
      cnt   <= width;
      pulse <= (width != '0);
    end else if (cnt != '0) begin
      cnt   <= cnt - PW_WIDTH'(1);
      pulse <= (cnt != PW_WIDTH'(1));
    end
  end

endmodule

// File: rtl/fsrc_seq_ctrl.sv
// rtl/fsrc_seq_ctrl.sv - SYSREF-aligned multi-channel trigger sequencer; FSRC_SEQ_CTRL_SEQ_CNT_EN adds seq_count
module fsrc_seq_ctrl
  import fsrc_seq_pkg::*;
#(
  parameter int NUM_TRIG      = DEF_NUM_TRIG,
  parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH,
  parameter int PW_WIDTH      = DEF_PW_WIDTH,
  parameter int REPEAT_WIDTH  = DEF_REPEAT_WIDTH
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              sysref_int,
  input  logic                              reg_start,
  input  logic                              ext_trig_in,
  input  logic                              ext_trig_en,
  input  logic                              abort,
  input  logic [NUM_TRIG*COUNTER_WIDTH-1:0] trig_cnt,
  input  logic [NUM_TRIG*PW_WIDTH-1:0]      trig_width,
  input  logic [COUNTER_WIDTH-1:0]          data_start_cnt,
  input  logic [REPEAT_WIDTH-1:0]           repeat_num,
  input  logic                              cont_en,
  output logic [NUM_TRIG-1:0]               trig_out,
  output logic                              data_start,
  output logic                              busy,
`ifdef FSRC_SEQ_CTRL_SEQ_CNT_EN
  output logic [SEQ_CNT_WIDTH-1:0]          seq_count,
`endif
  output logic                              done
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

  fsrc_seq_state_t                   state;
  logic                              sysref_q, sysref_re;
  logic                              ext_q, ext_re;
  logic                              start_pulse;
  logic [NUM_TRIG*COUNTER_WIDTH-1:0] sh_trig_cnt;
  logic [NUM_TRIG*PW_WIDTH-1:0]      sh_trig_width;
  logic [COUNTER_WIDTH-1:0]          sh_ds_cnt;
  logic [REPEAT_WIDTH-1:0]           sh_repeat;
  logic                              sh_cont;
  logic [COUNTER_WIDTH-1:0]          count, count_inc, epoch;
  logic [REPEAT_WIDTH-1:0]           iter;
  logic                              wrap;
  logic                              active, step, at_end, more;
  logic [NUM_TRIG-1:0]               fire;

  // Registered rising-edge detectors for SYSREF and the external trigger
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sysref_q  <= 1'b0;
      sysref_re <= 1'b0;
      ext_q     <= 1'b0;
      ext_re    <= 1'b0;
    end else begin
      sysref_q  <= sysref_int;
      sysref_re <= sysref_int & ~sysref_q;
      ext_q     <= ext_trig_in;
      ext_re    <= ext_trig_in & ~ext_q;
    end
  end

  assign start_pulse = ext_trig_en ? ext_re : reg_start;
  assign active      = (state == ARMED) || (state == RUN);
  assign busy        = active;
  assign count_inc   = (count == CNT_MAX) ? count : count + COUNTER_WIDTH'(1);
  // First SYSREF after arming, or after an iteration boundary, is epoch 0
  assign epoch       = ((state == ARMED) || wrap) ? '0 : count_inc;
  assign step        = sysref_re && active && !abort;
  assign at_end      = step && (epoch == sh_ds_cnt);
  assign more        = sh_cont || (iter < sh_repeat);

  // Sequencer FSM: shadow capture, epoch counting, iteration and completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      sh_trig_cnt   <= '0;
      sh_trig_width <= '0;
      sh_ds_cnt     <= '0;
      sh_repeat     <= '0;
      sh_cont       <= 1'b0;
      count         <= '0;
      iter          <= '0;
      wrap          <= 1'b0;
      data_start    <= 1'b0;
      done          <= 1'b0;
    end else begin
      data_start <= 1'b0;
      done       <= 1'b0;
      if (abort) begin
        state <= IDLE;
        count <= '0;
        iter  <= '0;
        wrap  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_pulse) begin
              sh_trig_cnt   <= trig_cnt;
              sh_trig_width <= trig_width;
              sh_ds_cnt     <= data_start_cnt;
              sh_repeat     <= repeat_num;
              sh_cont       <= cont_en;
              count         <= '0;
              iter          <= '0;
              wrap          <= 1'b0;
              state         <= ARMED;
            end
          end
          ARMED, RUN: begin
            if (sysref_re) begin
              count <= epoch;
              wrap  <= 1'b0;
              state <= RUN;
              if (at_end) begin
                data_start <= 1'b1;
                if (more) begin
                  wrap <= 1'b1;
                  if (!sh_cont) iter <= iter + REPEAT_WIDTH'(1);
                end else begin
                  state <= DONE;
                  done  <= 1'b1;
                end
              end
            end
          end
          DONE: begin
            state <= IDLE;
            count <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  for (genvar i = 0; i < NUM_TRIG; i++) begin : g_ch
    assign fire[i] = step
                  && (epoch == sh_trig_cnt[i*COUNTER_WIDTH +: COUNTER_WIDTH])
                  && (sh_trig_width[i*PW_WIDTH +: PW_WIDTH] != '0);

    fsrc_trig_stretch #(
      .PW_WIDTH(PW_WIDTH)
    ) u_stretch (
      .clk  (clk),
      .reset(reset),
      .clear(abort),
      .fire (fire[i]),
      .width(sh_trig_width[i*PW_WIDTH +: PW_WIDTH]),
      .pulse(trig_out[i])
    );
  end

`ifdef FSRC_SEQ_CTRL_SEQ_CNT_EN
  // Completed-iteration counter, saturating, restarted by an accepted start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_count <= '0;
    end else if (!abort && (state == IDLE) && start_pulse) begin
      seq_count <= '0;
    end else if (at_end && (seq_count != '1)) begin
      seq_count <= seq_count + SEQ_CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fsrc_seq_ctrl.sv
// tb/tb_fsrc_seq_ctrl.sv - self-checking bench for fsrc_seq_ctrl against an epoch-level model
module tb_fsrc_seq_ctrl;

  localparam int NT = 4, CW = 8, PW = 4, RW = 8, MAXC = 512;

  logic            clk = 1'b0, reset = 1'b1;
  logic            sysref_int = 1'b0, reg_start = 1'b0, ext_trig_in = 1'b0;
  logic            ext_trig_en = 1'b0, abort = 1'b0, cont_en = 1'b0;
  logic [NT*CW-1:0] trig_cnt = '0;
  logic [NT*PW-1:0] trig_width = '0;
  logic [CW-1:0]   data_start_cnt = '0;
  logic [RW-1:0]   repeat_num = '0;
  logic [NT-1:0]   trig_out;
  logic            data_start, busy, done;
`ifdef FSRC_SEQ_CTRL_SEQ_CNT_EN
  logic [15:0]     seq_count;
`endif

  int tests = 0, failed = 0;
  int tc[NT], tw[NT];
  int dcnt, rnum;
  bit cont, ext_en;
  bit sref_s[MAXC], rst_s[MAXC], ext_s[MAXC], abort_s[MAXC];
  int chg_cyc;
  logic [NT*CW-1:0] alt_trig_cnt;
  logic [6:0] obs_v[MAXC], exp_v[MAXC];

  always #5 clk = ~clk;

  fsrc_seq_ctrl dut (
    .clk(clk), .reset(reset), .sysref_int(sysref_int), .reg_start(reg_start),
    .ext_trig_in(ext_trig_in), .ext_trig_en(ext_trig_en), .abort(abort),
    .trig_cnt(trig_cnt), .trig_width(trig_width), .data_start_cnt(data_start_cnt),
    .repeat_num(repeat_num), .cont_en(cont_en), .trig_out(trig_out),
    .data_start(data_start), .busy(busy),
`ifdef FSRC_SEQ_CTRL_SEQ_CNT_EN
    .seq_count(seq_count),
`endif
    .done(done)
  );

  task automatic clear_sched();
    for (int c = 0; c < MAXC; c++) begin
      sref_s[c] = 0; rst_s[c] = 0; ext_s[c] = 0; abort_s[c] = 0;
    end
    chg_cyc = -1;
  endtask

  task automatic apply_cfg();
    for (int i = 0; i < NT; i++) begin
      trig_cnt[i*CW +: CW]   = CW'(tc[i]);
      trig_width[i*PW +: PW] = PW'(tw[i]);
    end
    data_start_cnt = CW'(dcnt);
    repeat_num     = RW'(rnum);
    cont_en        = cont;
    ext_trig_en    = ext_en;
  endtask

  task automatic sysref_train(input int first, input int per, input int n);
    for (int c = first; c < n; c++) if (((c - first) % per) < 3) sref_s[c] = 1;
  endtask

  task automatic simulate(input int n);
    for (int c = 0; c < n; c++) begin
      sysref_int = sref_s[c]; reg_start = rst_s[c]; ext_trig_in = ext_s[c]; abort = abort_s[c];
      if (c == chg_cyc) begin
        trig_cnt = alt_trig_cnt;
        data_start_cnt = data_start_cnt + 8'd1;
      end
      @(posedge clk); #1;
      obs_v[c] = {trig_out, data_start, done, busy};
    end
  endtask

  task automatic flush();
    sysref_int = 0; reg_start = 0; ext_trig_in = 0; abort = 0;
    repeat (24) @(posedge clk);
    #1;
  endtask

  // Expected outputs from the sequence of SYSREF edges: the k-th edge after start is
  // epoch k mod (end+1) of iteration k/(end+1); effects appear the cycle after the edge
  // is registered. Layout: {trig_out[3:0], data_start, done, busy}.
  task automatic model(input int s, input int ab, input int n);
    int k, last;
    bit fin;
    k = 0; last = n - 1; fin = 0;
    for (int c = 0; c < MAXC; c++) exp_v[c] = '0;
    for (int c = s; c < n && !fin; c++) begin
      if (sref_s[c] && (c == 0 || !sref_s[c-1])) begin
        int ep, it;
        ep = k % (dcnt + 1);
        it = k / (dcnt + 1);
        k++;
        for (int i = 0; i < NT; i++)
          if (tw[i] != 0 && tc[i] == ep)
            for (int j = c + 1; j <= c + tw[i] && j < MAXC; j++) exp_v[j][3+i] = 1'b1;
        if (ep == dcnt) begin
          exp_v[c+1][2] = 1'b1;
          if (!cont && it == rnum) begin
            exp_v[c+1][1] = 1'b1; last = c; fin = 1;
          end
        end
      end
    end
    for (int c = s; c <= last; c++) exp_v[c][0] = 1'b1;
    if (ab >= 0) for (int c = ab; c < MAXC; c++) exp_v[c] = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({trig_out, data_start, done, busy} !== 7'd0) begin
      failed++; $display("FAIL reset_state: got %b, expected 0000000", {trig_out, data_start, done, busy});
    end
`ifdef FSRC_SEQ_CTRL_SEQ_CNT_EN
    tests++;
    if (seq_count !== 16'd0) begin failed++; $display("FAIL reset_seq_count: got %0d, expected 0", seq_count); end
`endif
    reset = 1'b0;
    flush();
  endtask

  task automatic test_basic();
    clear_sched();
    tc = '{0, 1, 2, 3}; tw = '{4, 4, 4, 4}; dcnt = 5; rnum = 0; cont = 0; ext_en = 0;
    apply_cfg();
    rst_s[2] = 1;
    sysref_train(6, 16, 140);
    simulate(140);
    model(2, -1, 140);
    for (int c = 0; c < 140; c++) begin
      tests++;
      if (obs_v[c] !== exp_v[c]) begin failed++; $display("FAIL basic cycle %0d: got %b, expected %b", c, obs_v[c], exp_v[c]); end
    end
    flush();
  endtask

  task automatic test_repeat();
    clear_sched();
    tc = '{1, 2, 0, 0}; tw = '{3, 5, 0, 0}; dcnt = 2; rnum = 2; cont = 0; ext_en = 0;
    apply_cfg();
    rst_s[2] = 1;
    rst_s[40] = 1;
    sysref_train(5, 12, 130);
    simulate(130);
    model(2, -1, 130);
    for (int c = 0; c < 130; c++) begin
      tests++;
      if (obs_v[c] !== exp_v[c]) begin failed++; $display("FAIL repeat cycle %0d: got %b, expected %b", c, obs_v[c], exp_v[c]); end
    end
`ifdef FSRC_SEQ_CTRL_SEQ_CNT_EN
    tests++;
    if (seq_count !== 16'd3) begin failed++; $display("FAIL repeat_seq_count: got %0d, expected 3", seq_count); end
`endif
    flush();
  endtask

  task automatic test_abort();
    clear_sched();
    tc = '{1, 3, 0, 0}; tw = '{8, 2, 0, 0}; dcnt = 3; rnum = 0; cont = 1; ext_en = 0;
    apply_cfg();
    rst_s[2] = 1;
    abort_s[25] = 1;
    sysref_train(6, 16, 70);
    simulate(70);
    model(2, 25, 70);
    for (int c = 0; c < 70; c++) begin
      tests++;
      if (obs_v[c] !== exp_v[c]) begin failed++; $display("FAIL abort cycle %0d: got %b, expected %b", c, obs_v[c], exp_v[c]); end
    end
    flush();
    clear_sched();
    cont = 0; rnum = 1; dcnt = 1;
    apply_cfg();
    rst_s[1] = 1; abort_s[1] = 1;
    rst_s[4] = 1;
    sysref_train(8, 10, 70);
    simulate(70);
    model(4, -1, 70);
    for (int c = 0; c < 70; c++) begin
      tests++;
      if (obs_v[c] !== exp_v[c]) begin failed++; $display("FAIL restart cycle %0d: got %b, expected %b", c, obs_v[c], exp_v[c]); end
    end
    flush();
  endtask

  task automatic test_ext_trig();
    clear_sched();
    tc = '{0, 2, 1, 0}; tw = '{2, 3, 1, 0}; dcnt = 2; rnum = 0; cont = 0; ext_en = 1;
    apply_cfg();
    rst_s[1] = 1;
    rst_s[15] = 1;
    for (int c = 3; c < 13; c++) ext_s[c] = 1;
    for (int c = 30; c < 33; c++) ext_s[c] = 1;
    sysref_train(8, 14, 80);
    simulate(80);
    model(4, -1, 80);
    for (int c = 0; c < 80; c++) begin
      tests++;
      if (obs_v[c] !== exp_v[c]) begin failed++; $display("FAIL ext_trig cycle %0d: got %b, expected %b", c, obs_v[c], exp_v[c]); end
    end
    ext_en = 0;
    apply_cfg();
    flush();
  endtask

  task automatic test_zero_end();
    clear_sched();
    tc = '{0, 0, 7, 0}; tw = '{2, 0, 3, 1}; dcnt = 0; rnum = 2; cont = 0; ext_en = 0;
    apply_cfg();
    rst_s[1] = 1;
    sysref_train(4, 10, 60);
    simulate(60);
    model(1, -1, 60);
    for (int c = 0; c < 60; c++) begin
      tests++;
      if (obs_v[c] !== exp_v[c]) begin failed++; $display("FAIL zero_end cycle %0d: got %b, expected %b", c, obs_v[c], exp_v[c]); end
    end
    flush();
  endtask

  task automatic test_latched_and_reset();
    clear_sched();
    tc = '{2, 4, 1, 3}; tw = '{3, 2, 5, 1}; dcnt = 4; rnum = 0; cont = 0; ext_en = 0;
    apply_cfg();
    rst_s[2] = 1;
    chg_cyc = 20;
    alt_trig_cnt = {4{8'd0}};
    sysref_train(5, 12, 100);
    simulate(100);
    model(2, -1, 100);
    for (int c = 0; c < 100; c++) begin
      tests++;
      if (obs_v[c] !== exp_v[c]) begin failed++; $display("FAIL latched cycle %0d: got %b, expected %b", c, obs_v[c], exp_v[c]); end
    end
    flush();
    apply_cfg();
    clear_sched();
    rst_s[1] = 1;
    sysref_train(4, 12, 30);
    simulate(30);
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({trig_out, data_start, done, busy} !== 7'd0) begin
      failed++; $display("FAIL async_reset: got %b, expected 0000000", {trig_out, data_start, done, busy});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    flush();
    tests++;
    if (busy !== 1'b0) begin failed++; $display("FAIL post_reset_idle: busy %b, expected 0", busy); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int per, s, first, ab, n;
      clear_sched();
      dcnt = $urandom_range(0, 5); rnum = $urandom_range(0, 2);
      cont = ($urandom_range(0, 2) == 0); ext_en = 0;
      for (int i = 0; i < NT; i++) begin
        tc[i] = $urandom_range(0, 7); tw[i] = $urandom_range(0, 15);
      end
      apply_cfg();
      per = $urandom_range(8, 18);
      s = $urandom_range(1, 4);
      first = s + $urandom_range(1, 4);
      n = first + per * ((rnum + 1) * (dcnt + 1)) + 20;
      ab = -1;
      if (cont) begin
        ab = s + $urandom_range(10, 250);
        if (n < ab + 20) n = ab + 20;
        abort_s[ab] = 1;
      end
      rst_s[s] = 1;
      sysref_train(first, per, n);
      simulate(n);
      model(s, ab, n);
      for (int c = 0; c < n; c++) begin
        tests++;
        if (obs_v[c] !== exp_v[c]) begin failed++; $display("FAIL random%0d cycle %0d: got %b, expected %b", r, c, obs_v[c], exp_v[c]); end
      end
      flush();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_repeat();
    test_abort();
    test_ext_trig();
    test_zero_end();
    test_latched_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
